// File: rtl/serial_compare_ctrl_pkg.sv
// Shared definitions for the bit-serial magnitude comparator controller:
// FSM state encoding and the cascade start/reset values.
package serial_compare_ctrl_pkg;

    // 2-bit state encoding
    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_RUN_ENC  = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_RUN  = ST_RUN_ENC,
        ST_DONE = ST_DONE_ENC
    } state_t;

    // Cascade value meaning "no bit examined yet": operands considered equal
    localparam logic CASC_GT_RST = 1'b0;
    localparam logic CASC_LT_RST = 1'b0;
    localparam logic CASC_EQ_RST = 1'b1;

endpackage

// File: rtl/Comparator_1bit.sv
// One stage of an MSB-first magnitude comparator cascade. A decision already
// made by a more significant bit (GT_In/LT_In) is passed through; only while
// the higher bits are still equal does this bit get to decide.
module Comparator_1bit (
    input  logic DataIn0,
    input  logic DataIn1,
    input  logic GT_In,
    input  logic LT_In,
    input  logic EQ_In,
    output logic GT_Out,
    output logic LT_Out,
    output logic EQ_Out
);

    // Combinational cascade step
    always_comb begin
        GT_Out = GT_In | (EQ_In & DataIn0 & ~DataIn1);
        LT_Out = LT_In | (EQ_In & ~DataIn0 & DataIn1);
        EQ_Out = EQ_In & ~(DataIn0 ^ DataIn1);
    end

endmodule

// File: rtl/serial_compare_ctrl.sv
// Bit-serial magnitude comparator controller. Two WIDTH-bit operands are
// latched on Start and fed MSB-first through a single Comparator_1bit, one bit
// per clock, with the GT/LT/EQ cascade held in registers between steps.
//
// Handshake: Start is a request sampled only in IDLE; it is accepted on the
// edge where it is seen high in IDLE. Busy is high for every RUN cycle. Done
// is a one-cycle pulse (never together with Busy) marking GT_Out/LT_Out/EQ_Out
// valid; those outputs then hold until the next accepted Start.
module serial_compare_ctrl
    import serial_compare_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    output logic             Busy,
    output logic             Done,
    output logic             GT_Out,
    output logic             LT_Out,
    output logic             EQ_Out,
    output state_t           o_dbg_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sha;
    logic [WIDTH-1:0] r_shb;
    logic [CW-1:0]    r_cnt;
    logic             r_gt;
    logic             r_lt;
    logic             r_eq;
    logic             w_gt;
    logic             w_lt;
    logic             w_eq;
    logic             w_busy;
    logic             w_done;

    // The one shared comparator sees the current MSBs and the stored cascade
    Comparator_1bit u_cmp (
        .DataIn0 (r_sha[WIDTH-1]),
        .DataIn1 (r_shb[WIDTH-1]),
        .GT_In   (r_gt),
        .LT_In   (r_lt),
        .EQ_In   (r_eq),
        .GT_Out  (w_gt),
        .LT_Out  (w_lt),
        .EQ_Out  (w_eq)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status outputs; RUN ends on the last bit or, with early
    // exit, as soon as the freshly computed cascade says the operands differ
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if ((r_cnt == '0) || ((EARLY_EXIT != 0) && !w_eq)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: load operands on accept, then shift/compare/count in RUN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sha <= '0;
            r_shb <= '0;
            r_cnt <= CNT_INIT;
            r_gt  <= CASC_GT_RST;
            r_lt  <= CASC_LT_RST;
            r_eq  <= CASC_EQ_RST;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_sha <= DataA;
                        r_shb <= DataB;
                        r_cnt <= CNT_INIT;
                        r_gt  <= CASC_GT_RST;
                        r_lt  <= CASC_LT_RST;
                        r_eq  <= CASC_EQ_RST;
                    end
                end
                ST_RUN: begin
                    r_gt  <= w_gt;
                    r_lt  <= w_lt;
                    r_eq  <= w_eq;
                    r_sha <= {r_sha[WIDTH-2:0], 1'b0};
                    r_shb <= {r_shb[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt - CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign Busy        = w_busy;
    assign Done        = w_done;
    assign GT_Out      = r_gt;
    assign LT_Out      = r_lt;
    assign EQ_Out      = r_eq;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Bench for serial_compare_ctrl: two instances (early exit on and off) share
// the same stimulus. Each expected result is queued with the edge its Done
// must appear on and the number of Busy cycles that must precede it.
module tb_serial_compare_ctrl;
  import serial_compare_ctrl_pkg::*;

  localparam int W  = 8;
  localparam int EW = 43;  // {done_edge[31:0], busy_cycles[7:0], gt, lt, eq}

  logic clk;
  logic rst;
  logic start;
  logic [W-1:0] da;
  logic [W-1:0] db;

  logic busy1, done1, gt1, lt1, eq1;
  logic busy0, done0, gt0, lt0, eq0;
  state_t st1, st0;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int bc1 = 0;
  int bc0 = 0;

  logic [EW-1:0] exp1_q[$];
  logic [EW-1:0] exp0_q[$];

  serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1)) dut1 (
    .Clk(clk), .Reset(rst), .Start(start), .DataA(da), .DataB(db),
    .Busy(busy1), .Done(done1), .GT_Out(gt1), .LT_Out(lt1), .EQ_Out(eq1),
    .o_dbg_state(st1)
  );

  serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(0)) dut0 (
    .Clk(clk), .Reset(rst), .Start(start), .DataA(da), .DataB(db),
    .Busy(busy0), .Done(done0), .GT_Out(gt0), .LT_Out(lt0), .EQ_Out(eq0),
    .o_dbg_state(st0)
  );

  // clock / edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // reference: relation, latency to Done (edges after acceptance)
  function automatic logic [EW-1:0] mk_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input bit ee, input int k);
    int lat;
    bit found;
    logic gt, lt, eq;
    lat = W;
    found = 0;
    if (ee) begin
      for (int j = W - 1; j >= 0; j--) begin
        if (!found && (a[j] != b[j])) begin
          lat = W - j;
          found = 1;
        end
      end
    end
    gt = (a > b);
    lt = (a < b);
    eq = (a == b);
    return {32'(k + lat), 8'(lat), gt, lt, eq};
  endfunction

  // driver: present operands with Start for one edge and queue expectations
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    da = a;
    db = b;
    start = 1'b1;
    exp1_q.push_back(mk_exp(a, b, 1, cyc + 1));
    exp0_q.push_back(mk_exp(a, b, 0, cyc + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [EW-1:0] e;
    chk("ee1_onehot", 64'($onehot({gt1, lt1, eq1})), 1);
    chk("ee0_onehot", 64'($onehot({gt0, lt0, eq0})), 1);
    chk("ee1_busy_done_excl", 64'(busy1 & done1), 0);
    chk("ee0_busy_done_excl", 64'(busy0 & done0), 0);
    if (rst) begin
      bc1 = 0;
      bc0 = 0;
    end else begin
      if (busy1) bc1++;
      if (busy0) bc0++;
    end
    if (done1) begin
      if (exp1_q.size() == 0) begin
        chk("ee1_unexpected_done", 64'(exp1_q.size()), 1);
      end else begin
        e = exp1_q.pop_front();
        chk("ee1_result", 64'({gt1, lt1, eq1}), 64'(e[2:0]));
        chk("ee1_done_edge", 64'(cyc), 64'(e[42:11]));
        chk("ee1_busy_cycles", 64'(bc1), 64'(e[10:3]));
      end
      bc1 = 0;
    end
    if (done0) begin
      if (exp0_q.size() == 0) begin
        chk("ee0_unexpected_done", 64'(exp0_q.size()), 1);
      end else begin
        e = exp0_q.pop_front();
        chk("ee0_result", 64'({gt0, lt0, eq0}), 64'(e[2:0]));
        chk("ee0_done_edge", 64'(cyc), 64'(e[42:11]));
        chk("ee0_busy_cycles", 64'(bc0), 64'(e[10:3]));
      end
      bc0 = 0;
    end
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    da = '0;
    db = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'({busy1, busy0}), 0);
    chk("rst_done", 64'({done1, done0}), 0);
    chk("rst_ee1_rel", 64'({gt1, lt1, eq1}), 64'(3'b001));
    chk("rst_ee0_rel", 64'({gt0, lt0, eq0}), 64'(3'b001));
    chk("rst_state", 64'({st1, st0}), 64'({ST_IDLE, ST_IDLE}));
    rst = 1'b0;

    // idle with Start low: nothing may happen
    repeat (10) @(negedge clk);
    chk("idle_state", 64'({st1, st0}), 64'({ST_IDLE, ST_IDLE}));
    chk("idle_rel", 64'({gt1, lt1, eq1, gt0, lt0, eq0}), 64'(6'b001001));

    // equal operands: full length in both variants, then results hold
    start_op(8'h5A, 8'h5A);
    repeat (14) @(negedge clk);
    chk("hold_ee1_rel", 64'({gt1, lt1, eq1}), 64'(3'b001));
    chk("hold_ee0_rel", 64'({gt0, lt0, eq0}), 64'(3'b001));

    // MSB differs: 1-cycle early exit vs. full length
    start_op(8'h80, 8'h7F);
    repeat (12) @(negedge clk);
    chk("hold_gt", 64'({gt1, lt1, eq1, gt0, lt0, eq0}), 64'(6'b100100));

    // only LSB differs
    start_op(8'h12, 8'h13);
    repeat (12) @(negedge clk);
    chk("hold_lt", 64'({gt1, lt1, eq1, gt0, lt0, eq0}), 64'(6'b010010));

    // a second Start while running is ignored (operands 00/FF would give LT)
    start_op(8'h40, 8'h00);
    @(negedge clk);
    start = 1'b1;
    da = 8'h00;
    db = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("ignore_rel", 64'({gt1, lt1, eq1, gt0, lt0, eq0}), 64'(6'b100100));

    // reset mid-run abandons the operation without a Done
    @(negedge clk);
    da = 8'h01;
    db = 8'h02;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pre_reset_busy", 64'({busy1, busy0}), 64'(2'b11));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_state", 64'({st1, st0}), 64'({ST_IDLE, ST_IDLE}));
    chk("abort_rel", 64'({gt1, lt1, eq1, gt0, lt0, eq0}), 64'(6'b001001));
    chk("abort_busy", 64'({busy1, busy0, done1, done0}), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    // Start held high: acceptance every W+2 edges
    @(negedge clk);
    da = 8'hFF;
    db = 8'hFF;
    start = 1'b1;
    for (int n = 0; n < 3; n++) begin
      exp1_q.push_back(mk_exp(8'hFF, 8'hFF, 1, cyc + 1 + n * (W + 2)));
      exp0_q.push_back(mk_exp(8'hFF, 8'hFF, 0, cyc + 1 + n * (W + 2)));
    end
    repeat (25) @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);

    chk("ee1_pending", 64'(exp1_q.size()), 0);
    chk("ee0_pending", 64'(exp0_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
